// File: rtl/spi_slave_core_if.sv
// Signal bundle between the SPI slave core and the pads / register logic.
// The slave modport is the core's view; master is the pad-and-host side.
interface spi_slave_core_if #(
  parameter int WORD_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [WORD_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_core.sv
// Parametrised SPI slave: oversampled pins, all CPOL/CPHA modes, either bit order,
// one-entry transmit buffer and back-to-back words within a chip-select frame.
module spi_slave_core #(
  parameter int WORD_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst_n,
  spi_slave_core_if.slave bus
);
  localparam int CNT_W = $clog2(WORD_W);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
  logic                    sclk_prev, cs_prev;
  logic                    sclk_s, cs_s, mosi_s;
  logic                    lead_edge, trail_edge, sample_edge, shift_edge;
  logic                    cs_fall, cs_rise;
  logic                    load, smp, shf, drop;
  logic [CNT_W-1:0]        cnt_q;
  logic [WORD_W-1:0]       rx_sr, rx_next, rx_data_q, tx_sr, buf_data, load_word;
  logic                    buf_full, miso_q, rx_valid_q, underrun_q;

  function automatic logic first_bit(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? w[WORD_W-1] : w[0];
  endfunction

  function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? {w[WORD_W-2:0], 1'b0} : {1'b0, w[WORD_W-1:1]};
  endfunction

  // Synchronisers reset to the pins' idle levels so no edge is seen on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= CPOL;
      cs_prev   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign lead_edge   = (sclk_prev == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_prev != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev && !cs_s;
  assign cs_rise     = !cs_prev && cs_s;
  assign rx_next     = MSB_FIRST ? {rx_sr[WORD_W-2:0], mosi_s} : {mosi_s, rx_sr[WORD_W-1:1]};
  assign load_word   = buf_full ? buf_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_d = state_q;
    load    = 1'b0;
    smp     = 1'b0;
    shf     = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          drop    = 1'b1;
        end else begin
          smp  = sample_edge;
          load = sample_edge && (cnt_q == CNT_W'(WORD_W - 1));
          // In CPHA=0 the first bit is already on MISO after a load, so the shift
          // edge that trails a word's final sample must not advance the new word.
          shf  = shift_edge && (CPHA || cnt_q != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rx_sr      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_sr      <= '0;
      miso_q     <= 1'b0;
      underrun_q <= 1'b0;
      buf_full   <= 1'b0;
      buf_data   <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;

      if (smp) rx_sr <= rx_next;

      if (drop)     cnt_q <= '0;
      else if (smp) cnt_q <= load ? '0 : cnt_q + 1'b1;

      if (smp && load) begin
        rx_data_q  <= rx_next;
        rx_valid_q <= 1'b1;
      end

      if (load) begin
        underrun_q <= !buf_full;
        if (CPHA) begin
          tx_sr <= load_word;
        end else begin
          tx_sr  <= advance(load_word);
          miso_q <= first_bit(load_word);
        end
      end else if (shf) begin
        tx_sr  <= advance(tx_sr);
        miso_q <= first_bit(tx_sr);
      end else if (drop) begin
        miso_q <= 1'b0;
      end

      // A write is only possible into an empty buffer, so it never collides with
      // a load that drains a full one.
      if (bus.tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= bus.tx_data;
      end else if (load) begin
        buf_full <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state_q == ACTIVE);
  assign bus.miso_oe     = bus.busy;
  assign bus.miso        = miso_q && bus.busy;
  assign bus.tx_ready    = !buf_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
endmodule
